// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and store byte/half merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    lane_byte = word[{byte_sel, 3'b000} +: 8];
    lane_half = byte_sel[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = word;
    endcase
  end

  // Overlay the store data onto the old word, touching only the addressed lane.
  always_comb begin
    merged_word = word;
    case (funct3)
      F3_B: merged_word[{byte_sel, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_sel[1]) merged_word[31:16] = wdata[15:0];
        else             merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end driving a word-wide synchronous-read memory.
// SW writes directly; SB/SH do read-modify-write; loads extract and extend a lane.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int dataW = 32,
  parameter int addrW = 16
) (
  input  logic             sysCLK,
  input  logic             resetN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqWe,
  input  logic [2:0]       reqFunct3,
  input  logic [31:0]      reqAddr,
  input  logic [31:0]      reqWData,
  output logic             rspValid,
  output logic [dataW-1:0] rspRData,
  output logic             rspErr,
  output logic [addrW-1:0] memAddr,
  output logic [dataW-1:0] memDataW,
  output logic             memRW,
  input  logic [dataW-1:0] memDataR
);

  lsu_state_t  state_reg;
  logic        req_we_reg;
  logic [2:0]  req_f3_reg;
  logic [1:0]  req_sel_reg;
  logic [31:0] req_wdata_reg;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;
  logic        req_bad;
  logic        addr_unused;

  // Byte-address bits above the word-address range are deliberately dropped.
  assign addr_unused = ^reqAddr[31:addrW+2];

  assign req_bad  = f3_illegal(reqWe, reqFunct3) || f3_misaligned(reqFunct3, reqAddr[1:0]);
  assign reqReady = (state_reg == IDLE);
  assign memRW    = (state_reg == WRITE);

  lsu_byte_lane u_lane (
    .word        (memDataR),
    .wdata       (req_wdata_reg),
    .byte_sel    (req_sel_reg),
    .funct3      (req_f3_reg),
    .load_data   (lane_load),
    .merged_word (lane_merged)
  );

  // Request latch, FSM and registered response/memory outputs.
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= IDLE;
      req_we_reg    <= 1'b0;
      req_f3_reg    <= 3'd0;
      req_sel_reg   <= 2'd0;
      req_wdata_reg <= 32'd0;
      rspValid      <= 1'b0;
      rspRData      <= '0;
      rspErr        <= 1'b0;
      memAddr       <= '0;
      memDataW      <= '0;
    end else begin
      rspValid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reqValid) begin
            req_we_reg    <= reqWe;
            req_f3_reg    <= reqFunct3;
            req_sel_reg   <= reqAddr[1:0];
            req_wdata_reg <= reqWData;
            rspRData      <= '0;
            rspErr        <= 1'b0;
            if (req_bad) begin
              state_reg <= ERR;
            end else begin
              memAddr <= reqAddr[addrW+1:2];
              if (reqWe && reqFunct3 == F3_W) begin
                memDataW  <= reqWData;
                state_reg <= WRITE;
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        READ: state_reg <= DATA;
        DATA: begin
          if (req_we_reg) begin
            memDataW  <= lane_merged;
            rspRData  <= '0;
            rspErr    <= 1'b0;
            state_reg <= WRITE;
          end else begin
            rspRData  <= lane_load;
            rspValid  <= 1'b1;
            state_reg <= RESP;
          end
        end
        WRITE: begin
          rspValid  <= 1'b1;
          state_reg <= RESP;
        end
        ERR: begin
          rspErr    <= 1'b1;
          rspRData  <= '0;
          rspValid  <= 1'b1;
          state_reg <= RESP;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
